deserializator: RTL and testbench

Serial-to-parallel receiver for the one-bit stream produced by `serializator`. It collects MSB-first bits qualified by a valid strobe into a frame of up to 16 bits. It publishes the frame as a left-aligned word with a length code in the same `data_mod` encoding the serializer accepts. It sits at the receiving end of the serial link, or in loopback with `serializator` for bring-up.

---
 rtl/deser_pkg.sv | 17 +
 rtl/deserializator.sv | 151 +++++++++++++++
 tb/tb_deserializator.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/deser_pkg.sv
// Shared definitions for the serial link: frame limits and receiver state encoding.
package deser_pkg;

    // Longest frame in bits; also the parallel word width on both link ends.
    localparam int DATA_W  = 16;
    // Width of the length code; a code of 0 stands for a full DATA_W-bit frame.
    localparam int MOD_W   = 4;
    // Frames shorter than this are treated as line noise and reported as errors.
    localparam int MIN_LEN = 3;

    // IDLE: nothing held. RECV: a partial frame of 1..DATA_W-1 bits is held.
    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

endpackage : deser_pkg

// File: rtl/deserializator.sv
// Serial-to-parallel receiver. Collects an MSB-first bit run qualified by
// ser_data_val_i into a left-aligned word plus a length code. A frame closes
// either when the valid strobe drops or when DATA_W bits have been collected.
// Frames shorter than MIN_LEN are dropped and flagged on err_o.
//
// Handshake: there is no backpressure. ser_data_val_i high on a rising edge
// means ser_data_i is taken on that edge. data_val_o and err_o are one-cycle
// pulses; data_o/data_mod_o are only meaningful in the data_val_o cycle but
// hold their value until the next successful frame.
module deserializator #(
    parameter int DATA_W  = deser_pkg::DATA_W,
    parameter int MOD_W   = deser_pkg::MOD_W,
    parameter int MIN_LEN = deser_pkg::MIN_LEN
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic              ser_data_i,
    input  logic              ser_data_val_i,
    output logic [DATA_W-1:0] data_o,
    output logic [MOD_W-1:0]  data_mod_o,
    output logic              data_val_o,
    output logic              err_o,
    output logic              busy_o,
    output deser_pkg::state_t state_o
);

    import deser_pkg::*;

    // Single-bit mask at the MSB; shifted right by the bit count to find the
    // slot of the next incoming bit.
    localparam logic [DATA_W-1:0] MSB_ONE  = DATA_W'(1) << (DATA_W - 1);
    localparam logic [MOD_W:0]    FULL_CNT = (MOD_W + 1)'(DATA_W);
    localparam logic [MOD_W:0]    MIN_CNT  = (MOD_W + 1)'(MIN_LEN);

    state_t            state_q, state_d;
    logic [MOD_W:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0] sh_q, sh_d;

    logic [DATA_W-1:0] data_d;
    logic [MOD_W-1:0]  mod_d;
    logic              val_d;
    logic              err_d;

    // Frame-close request for this edge: length and word including the bit
    // sampled on the same edge.
    logic              close;
    logic [MOD_W:0]    close_cnt;
    logic [DATA_W-1:0] close_word;

    // Next-state, shift-register and frame-close decisions.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        close      = 1'b0;
        close_cnt  = cnt_q;
        close_word = sh_q;

        unique case (state_q)
            IDLE: begin
                if (ser_data_val_i) begin
                    // New frame: drop everything left over from the previous one.
                    sh_d  = ser_data_i ? MSB_ONE : '0;
                    cnt_d = (MOD_W + 1)'(1);
                    if (cnt_d == FULL_CNT) begin
                        // Degenerate 1-bit word: the frame is already full.
                        close      = 1'b1;
                        close_cnt  = cnt_d;
                        close_word = sh_d;
                        cnt_d      = '0;
                    end else begin
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (ser_data_val_i) begin
                    sh_d  = ser_data_i ? (sh_q | (MSB_ONE >> cnt_q)) : sh_q;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == FULL_CNT) begin
                        // Full frame closes on the edge that takes its last bit,
                        // so a following frame can start on the very next edge.
                        close      = 1'b1;
                        close_cnt  = cnt_d;
                        close_word = sh_d;
                        cnt_d      = '0;
                        state_d    = IDLE;
                    end
                end else begin
                    close      = 1'b1;
                    close_cnt  = cnt_q;
                    close_word = sh_q;
                    cnt_d      = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Publish on a legal close; a short frame only raises err and leaves
        // the last good word in place.
        data_d = data_o;
        mod_d  = data_mod_o;
        val_d  = 1'b0;
        err_d  = 1'b0;
        if (close) begin
            if (close_cnt >= MIN_CNT) begin
                data_d = close_word;
                mod_d  = close_cnt[MOD_W-1:0];
                val_d  = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // FSM, counter and shift register.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            data_o     <= '0;
            data_mod_o <= '0;
            data_val_o <= 1'b0;
            err_o      <= 1'b0;
        end else begin
            data_o     <= data_d;
            data_mod_o <= mod_d;
            data_val_o <= val_d;
            err_o      <= err_d;
        end
    end

    assign busy_o  = (state_q == RECV);
    assign state_o = state_q;

endmodule : deserializator

// File: tb/tb_deserializator.sv
// Directed bench for deserializator: expected frames go into a queue as they
// are driven and are popped when the receiver pulses data_val_o or err_o.
module tb_deserializator;

    import deser_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic         is_err;
        logic [W-1:0] word;
        logic [3:0]   mod;
    } exp_t;

    logic         clk_i = 1'b0;
    logic         arst_ni = 1'b0;
    logic         ser_data_i = 1'b0;
    logic         ser_data_val_i = 1'b0;
    logic [W-1:0] data_o;
    logic [3:0]   data_mod_o;
    logic         data_val_o;
    logic         err_o;
    logic         busy_o;
    state_t       state_o;

    exp_t         exp_q[$];
    int           tests = 0;
    int           fails = 0;
    int           busy_cycles = 0;
    logic [W-1:0] last_word = '0;
    logic [3:0]   last_mod = '0;

    deserializator dut (
        .clk_i          (clk_i),
        .arst_ni        (arst_ni),
        .ser_data_i     (ser_data_i),
        .ser_data_val_i (ser_data_val_i),
        .data_o         (data_o),
        .data_mod_o     (data_mod_o),
        .data_val_o     (data_val_o),
        .err_o          (err_o),
        .busy_o         (busy_o),
        .state_o        (state_o)
    );

    // Clock: 10 ns period.
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every pulse must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (arst_ni) begin
            if (busy_o) busy_cycles++;
            if (data_val_o && err_o) check("val_err_both", 32'd1, 32'd0);
            if (data_val_o || err_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", {30'd0, err_o, data_val_o}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind", {31'd0, err_o}, {31'd0, e.is_err});
                    check("word", {16'd0, data_o}, {16'd0, e.word});
                    check("mod", {28'd0, data_mod_o}, {28'd0, e.mod});
                end
            end
        end
    end

    // Expected receive-side view of a frame of len bits (1..16).
    function automatic exp_t model(input logic [W-1:0] word, input int len);
        exp_t         e;
        logic [W-1:0] ones;
        ones = '1;
        if (len >= MIN_LEN) begin
            e.is_err = 1'b0;
            e.word   = word & ~(ones >> len);
            e.mod    = 4'(len % W);
        end else begin
            e.is_err = 1'b1;
            e.word   = last_word;
            e.mod    = last_mod;
        end
        return e;
    endfunction

    // Drive len bits MSB-first, then gap idle cycles.
    task automatic send_frame(input logic [W-1:0] word, input int len, input int gap);
        exp_t e;
        e = model(word, len);
        if (!e.is_err) begin
            last_word = e.word;
            last_mod  = e.mod;
        end
        exp_q.push_back(e);
        for (int i = 0; i < len; i++) begin
            @(negedge clk_i);
            ser_data_val_i = 1'b1;
            ser_data_i     = word[W-1-i];
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clk_i);
            ser_data_val_i = 1'b0;
            ser_data_i     = 1'b0;
        end
    endtask

    // Transmit side of the link as the serializer would: mod 0 means 16 bits.
    task automatic serialize(input logic [W-1:0] word, input logic [3:0] mod, input int gap);
        send_frame(word, (mod == 4'd0) ? W : int'(mod), gap);
    endtask

    // Bounded wait for all expected pulses.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check(tag, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        // Reset.
        #12;
        check("rst_data", {16'd0, data_o}, 32'd0);
        check("rst_mod", {28'd0, data_mod_o}, 32'd0);
        check("rst_val", {31'd0, data_val_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);
        check("rst_busy", {31'd0, busy_o}, 32'd0);
        check("rst_state", {31'd0, state_o}, 32'd0);
        @(negedge clk_i);
        arst_ni = 1'b1;
        repeat (2) @(negedge clk_i);

        // 6-bit frame 101100; busy for exactly 6 cycles.
        busy_cycles = 0;
        send_frame(16'hB000, 6, 1);
        drain("drain_6bit");
        check("busy_cycles_6", busy_cycles, 32'd6);

        // Full frame followed at once by a 1-bit frame.
        send_frame(16'hB005, 16, 0);
        @(negedge clk_i);
        check("full_pulse_timing", {31'd0, data_val_o}, 32'd1);
        ser_data_val_i = 1'b1;
        ser_data_i     = 1'b1;
        exp_q.push_back(model(16'h8000, 1));
        @(negedge clk_i);
        ser_data_val_i = 1'b0;
        ser_data_i     = 1'b0;
        drain("drain_b2b_short");
        check("held_after_err", {16'd0, data_o}, 32'h0000B005);

        // 2-bit frame is an error; output word holds.
        send_frame(16'hC000, 2, 2);
        drain("drain_2bit");
        check("held_mod_after_err", {28'd0, data_mod_o}, 32'd0);

        // Reset during a partial frame.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            ser_data_val_i = 1'b1;
            ser_data_i     = 1'(i % 2);
        end
        @(posedge clk_i);
        #1 arst_ni = 1'b0;
        #1;
        check("arst_data", {16'd0, data_o}, 32'd0);
        check("arst_mod", {28'd0, data_mod_o}, 32'd0);
        check("arst_busy", {31'd0, busy_o}, 32'd0);
        check("arst_state", {31'd0, state_o}, 32'd0);
        #2 arst_ni = 1'b1;
        @(negedge clk_i);
        ser_data_val_i = 1'b0;
        last_word = '0;
        last_mod  = '0;
        repeat (3) @(negedge clk_i);
        send_frame(16'hB000, 6, 1);
        drain("drain_after_rst");

        // Loopback-style pairs, then two back-to-back full frames.
        serialize(16'hB000, 4'd6, 1);
        serialize(16'hB005, 4'd0, 1);
        drain("drain_loopback");
        send_frame(16'h1234, 16, 0);
        send_frame(16'hFEDC, 16, 1);
        drain("drain_b2b_full");

        // Random lengths, including the MIN_LEN boundary.
        send_frame(16'hE000, MIN_LEN, 1);
        send_frame(16'hFFFF, 15, 1);
        for (int i = 0; i < 12; i++) begin
            send_frame(16'($urandom_range(0, 16'hFFFF)), $urandom_range(1, 16), 1);
        end
        drain("drain_random");

        repeat (3) @(negedge clk_i);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_deserializator
